// File: rtl/load_buffer.sv
// Load buffer: tracks in-flight loads through store-queue forwarding, memory
// access and writeback, with flush squashing and out-of-order memory responses.
module load_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PRW   = 6,
    parameter int ROBW  = 5,
    parameter int LSQW  = 3,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_base,
    input  logic [11:0]     in_imm,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [PRW-1:0]  in_dest_pr,
    input  logic [ROBW-1:0] in_rob,
    input  logic [LSQW-1:0] in_sq_tail,
    output logic            sq_valid,
    output logic [XLEN-1:0] sq_addr,
    output logic [LSQW-1:0] sq_tail,
    input  logic            sq_stall,
    input  logic [3:0]      sq_bytes,
    input  logic [XLEN-1:0] sq_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [TW-1:0]   mem_req_tag,
    input  logic            mem_resp_valid,
    input  logic [TW-1:0]   mem_resp_tag,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            out_valid,
    input  logic            out_stall,
    output logic [PRW-1:0]  out_dest_pr,
    output logic [ROBW-1:0] out_rob,
    output logic [XLEN-1:0] out_data
);
    typedef enum logic [2:0] {
        S_FREE, S_SQ, S_MEM_REQ, S_MEM_WAIT, S_DONE, S_DRAIN
    } state_e;

    state_e          state_q [DEPTH];
    state_e          state_d [DEPTH];
    logic [XLEN-1:0] addr_q [DEPTH], addr_d [DEPTH];
    logic [1:0]      size_q [DEPTH], size_d [DEPTH];
    logic            is_unsigned_q [DEPTH], is_unsigned_d [DEPTH];
    logic [PRW-1:0]  dest_pr_q [DEPTH], dest_pr_d [DEPTH];
    logic [ROBW-1:0] rob_q [DEPTH], rob_d [DEPTH];
    logic [LSQW-1:0] sq_tail_q [DEPTH], sq_tail_d [DEPTH];
    logic [3:0]      use_bytes_q [DEPTH], use_bytes_d [DEPTH];
    logic [3:0]      fwd_bytes_q [DEPTH], fwd_bytes_d [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH], data_d [DEPTH];

    // Hold flags pin the presented entry so a stalled request/output stays stable.
    logic            mem_hold_q, mem_hold_d;
    logic [TW-1:0]   mem_hold_idx_q, mem_hold_idx_d;
    logic            out_hold_q, out_hold_d;
    logic [TW-1:0]   out_hold_idx_q, out_hold_idx_d;

    logic            free_any, sq_any, mr_any, done_any, mr_vld;
    logic [TW-1:0]   alloc_idx, sq_idx, mr_idx, done_idx, mr_sel, out_sel;
    logic [DEPTH-1:0] resp_hit;
    logic [XLEN-1:0] issue_addr, merged, out_word, out_fmt;
    logic [1:0]      out_off;
    logic [7:0]      out_byte;
    logic [15:0]     out_half;

    function automatic logic [3:0] use_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   use_mask = 4'b0001 << off;
            2'b01:   use_mask = off[1] ? 4'b1100 : 4'b0011;
            default: use_mask = 4'b1111;
        endcase
    endfunction

    assign issue_addr = in_base + {{(XLEN-12){in_imm[11]}}, in_imm};

    // Descending scan so the lowest matching index wins each selection.
    always_comb begin
        free_any = 1'b0; alloc_idx = '0;
        sq_any   = 1'b0; sq_idx    = '0;
        mr_any   = 1'b0; mr_idx    = '0;
        done_any = 1'b0; done_idx  = '0;
        resp_hit = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE)    begin free_any = 1'b1; alloc_idx = TW'(i); end
            if (state_q[i] == S_SQ)      begin sq_any   = 1'b1; sq_idx    = TW'(i); end
            if (state_q[i] == S_MEM_REQ) begin mr_any   = 1'b1; mr_idx    = TW'(i); end
            if (state_q[i] == S_DONE)    begin done_any = 1'b1; done_idx  = TW'(i); end
            resp_hit[i] = mem_resp_valid && (mem_resp_tag == TW'(i));
        end
    end

    assign in_ready      = free_any && !flush;
    assign mr_vld        = mem_hold_q || mr_any;
    assign mr_sel        = mem_hold_q ? mem_hold_idx_q : mr_idx;
    assign out_sel       = out_hold_q ? out_hold_idx_q : done_idx;
    assign out_valid     = (out_hold_q || done_any) && !flush;
    assign sq_valid      = sq_any;
    assign sq_addr       = sq_any ? {addr_q[sq_idx][XLEN-1:2], 2'b00} : '0;
    assign sq_tail       = sq_any ? sq_tail_q[sq_idx] : '0;
    assign mem_req_valid = mr_vld;
    assign mem_req_addr  = mr_vld ? {addr_q[mr_sel][XLEN-1:2], 2'b00} : '0;
    assign mem_req_tag   = mr_vld ? mr_sel : '0;
    assign out_dest_pr   = out_valid ? dest_pr_q[out_sel] : '0;
    assign out_rob       = out_valid ? rob_q[out_sel] : '0;
    assign out_data      = out_valid ? out_fmt : '0;

    always_comb begin
        out_word = data_q[out_sel];
        out_off  = addr_q[out_sel][1:0];
        out_byte = out_word[{out_off, 3'b000} +: 8];
        out_half = out_off[1] ? out_word[31:16] : out_word[15:0];
        case (size_q[out_sel])
            2'b00: out_fmt = is_unsigned_q[out_sel] ? {{(XLEN-8){1'b0}}, out_byte}
                                                    : {{(XLEN-8){out_byte[7]}}, out_byte};
            2'b01: out_fmt = is_unsigned_q[out_sel] ? {{(XLEN-16){1'b0}}, out_half}
                                                    : {{(XLEN-16){out_half[15]}}, out_half};
            default: out_fmt = out_word;
        endcase
    end

    assign mem_hold_d     = !flush && mr_vld && !mem_req_ready;
    assign mem_hold_idx_d = mr_sel;
    assign out_hold_d     = out_valid && out_stall;
    assign out_hold_idx_d = out_sel;

    always_comb begin
        merged = mem_resp_data;
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i]       = state_q[i];
            addr_d[i]        = addr_q[i];
            size_d[i]        = size_q[i];
            is_unsigned_d[i] = is_unsigned_q[i];
            dest_pr_d[i]     = dest_pr_q[i];
            rob_d[i]         = rob_q[i];
            sq_tail_d[i]     = sq_tail_q[i];
            use_bytes_d[i]   = use_bytes_q[i];
            fwd_bytes_d[i]   = fwd_bytes_q[i];
            data_d[i]        = data_q[i];
            merged = mem_resp_data;
            for (int b = 0; b < 4; b++) begin
                if (fwd_bytes_q[i][b]) merged[8*b +: 8] = data_q[i][8*b +: 8];
            end
            if (flush) begin
                // Anything already sent to memory must drain its response before reuse.
                case (state_q[i])
                    S_MEM_WAIT, S_DRAIN: state_d[i] = resp_hit[i] ? S_FREE : S_DRAIN;
                    S_MEM_REQ: state_d[i] = (mr_vld && mem_req_ready && mr_sel == TW'(i))
                                            ? S_DRAIN : S_FREE;
                    default: state_d[i] = S_FREE;
                endcase
            end else begin
                case (state_q[i])
                    S_FREE: if (in_valid && in_ready && alloc_idx == TW'(i)) begin
                        state_d[i]       = S_SQ;
                        addr_d[i]        = issue_addr;
                        size_d[i]        = in_size;
                        is_unsigned_d[i] = in_unsigned;
                        dest_pr_d[i]     = in_dest_pr;
                        rob_d[i]         = in_rob;
                        sq_tail_d[i]     = in_sq_tail;
                        use_bytes_d[i]   = use_mask(in_size, issue_addr[1:0]);
                        fwd_bytes_d[i]   = '0;
                        data_d[i]        = '0;
                    end
                    S_SQ: if (sq_idx == TW'(i) && !sq_stall) begin
                        data_d[i] = sq_data;
                        if ((sq_bytes & use_bytes_q[i]) == use_bytes_q[i]) begin
                            state_d[i] = S_DONE;
                        end else begin
                            state_d[i]     = S_MEM_REQ;
                            fwd_bytes_d[i] = sq_bytes;
                        end
                    end
                    S_MEM_REQ: if (mr_vld && mr_sel == TW'(i) && mem_req_ready) state_d[i] = S_MEM_WAIT;
                    S_MEM_WAIT: if (resp_hit[i]) begin
                        state_d[i] = S_DONE;
                        data_d[i]  = merged;
                    end
                    S_DRAIN: if (resp_hit[i]) state_d[i] = S_FREE;
                    S_DONE: if (out_valid && out_sel == TW'(i) && !out_stall) state_d[i] = S_FREE;
                    default: state_d[i] = S_FREE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]       <= S_FREE;
                addr_q[i]        <= '0;
                size_q[i]        <= '0;
                is_unsigned_q[i] <= 1'b0;
                dest_pr_q[i]     <= '0;
                rob_q[i]         <= '0;
                sq_tail_q[i]     <= '0;
                use_bytes_q[i]   <= '0;
                fwd_bytes_q[i]   <= '0;
                data_q[i]        <= '0;
            end
            mem_hold_q     <= 1'b0;
            mem_hold_idx_q <= '0;
            out_hold_q     <= 1'b0;
            out_hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]       <= state_d[i];
                addr_q[i]        <= addr_d[i];
                size_q[i]        <= size_d[i];
                is_unsigned_q[i] <= is_unsigned_d[i];
                dest_pr_q[i]     <= dest_pr_d[i];
                rob_q[i]         <= rob_d[i];
                sq_tail_q[i]     <= sq_tail_d[i];
                use_bytes_q[i]   <= use_bytes_d[i];
                fwd_bytes_q[i]   <= fwd_bytes_d[i];
                data_q[i]        <= data_d[i];
            end
            mem_hold_q     <= mem_hold_d;
            mem_hold_idx_q <= mem_hold_idx_d;
            out_hold_q     <= out_hold_d;
            out_hold_idx_q <= out_hold_idx_d;
        end
    end
endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- XLEN, 32, data/address width.
- DEPTH, 4, outstanding load entries; power of two, at least 2.
- PRW, 6, physical register tag width.
- ROBW, 5, ROB index width.
- LSQW, 3, store-queue tail width.
- TW = clog2(DEPTH), memory tag width.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, squash all loads.
- in_valid / in_ready, in / out, 1 / 1, issue handshake.
- in_base, in, XLEN, rs1 value.
- in_imm, in, 12, I-immediate.
- in_size, in, 2: 00 = byte, 01 = half, 10 = word.
- in_unsigned, in, 1, zero-extend.
- in_dest_pr, in, PRW.
- in_rob, in, ROBW.
- in_sq_tail, in, LSQW.
- sq_valid, out, 1.
- sq_addr, out, XLEN, word-aligned.
- sq_tail, out, LSQW.
- sq_stall, in, 1.
- sq_bytes, in, 4.
- sq_data, in, XLEN (same-cycle response).
- mem_req_valid, out, 1.
- mem_req_ready, in, 1.
- mem_req_addr, out, XLEN, word-aligned.
- mem_req_tag, out, TW.
- mem_resp_valid, in, 1.
- mem_resp_tag, in, TW.
- mem_resp_data, in, XLEN.
- out_valid, out, 1.
- out_stall, in, 1.
- out_dest_pr, out, PRW.
- out_rob, out, ROBW.
- out_data, out, XLEN.

Function
REQ-003 Each entry SHALL hold a state from {FREE, SQ, MEM_REQ, MEM_WAIT, DONE, DRAIN} plus: addr, size, unsigned, dest_pr, rob, sq_tail, usebytes, fwd_bytes, data.
REQ-004 Address SHALL be computed as in_base + sign-extended in_imm, modulo 2^XLEN.
REQ-005 usebytes SHALL be derived from size and addr:
- byte: one-hot at addr[1:0].
- half: 0011 when addr[1] = 0, 1100 when addr[1] = 1; addr[0] is ignored.
- word: 1111; addr[1:0] are ignored.
REQ-006 in_ready SHALL equal (any entry FREE) and not flush; evaluation uses current-cycle state, so an entry freed this cycle is not reusable until the next cycle.
REQ-007 When in_valid and in_ready are both high, the lowest-index FREE entry SHALL move to SQ at the next edge.
REQ-008 sq_valid SHALL be high when any entry is in SQ; sq_addr and sq_tail SHALL come from the lowest-index SQ entry.
REQ-009 For the selected SQ entry:
- If sq_stall: stay in SQ.
- Else if (sq_bytes & usebytes) == usebytes: capture sq_data and go to DONE.
- Else: capture fwd_bytes = sq_bytes and data = sq_data, and go to MEM_REQ.
REQ-010 mem_req_valid SHALL present the lowest-index MEM_REQ entry, with mem_req_tag = entry index; the entry moves to MEM_WAIT when mem_req_ready is high; mem_req_addr SHALL stay stable while mem_req_ready is low.
REQ-011 On mem_resp_valid, the entry indexed by mem_resp_tag SHALL act by state:
- MEM_WAIT: data = mem_resp_data with bytes in fwd_bytes replaced by stored forwarded bytes; go to DONE.
- DRAIN: go to FREE.
- Any other state: the response is ignored.
REQ-012 out_valid SHALL be high when any entry is DONE and flush is low; output comes from the lowest-index DONE entry.
REQ-013 out_data SHALL be the selected byte/half, sign-extended unless unsigned; unsigned half from bytes 3:2 SHALL land in out_data[15:0].
REQ-014 When out_valid is high and out_stall is low, the output entry SHALL go to FREE at the next edge; while out_stall is high, outputs SHALL hold stable.
REQ-015 Flush SHALL set every entry to FREE at the next edge, except MEM_WAIT entries, which go to DRAIN; DRAIN entries SHALL not be allocatable.
REQ-016 Flush SHALL take priority over issue, SQ, memory and output updates in the same cycle.
REQ-017 Minimum latency from accepted issue (cycle 0):
- SQ full forward: out_valid in cycle 2.
- Memory path: request in cycle 2; with the response in cycle 3, out_valid in cycle 4.
REQ-018 When all DEPTH entries are busy, in_ready SHALL be 0; no issue SHALL be lost or overwritten.

Reset
REQ-019 While reset is high, all entries SHALL go to FREE at the next edge and all stored fields SHALL clear to 0.
REQ-020 After reset, outputs SHALL read: in_ready = 1; sq_valid, mem_req_valid and out_valid = 0; all data, address and tag outputs = 0.
REQ-021 Reset SHALL dominate flush and all other inputs; a memory response arriving after reset SHALL be ignored.

Verification
REQ-022 Full forward: LW, base 0x100, imm 4; sq_bytes = 1111, sq_data = 0xDEADBEEF.
  -> sq_addr = 0x104 in cycle 1; out_data = 0xDEADBEEF in cycle 2; no memory request.
REQ-023 Partial forward: LH, addr 0x202; sq_bytes = 0100, sq_data byte2 = 0xAA; memory returns 0x80110000.
  -> out_data = 0xFFFF80AA.
REQ-024 Out-of-order responses: two LBU loads, entries 0 and 1, memory responds tag 1 then tag 0.
  -> entry 1 completes first with correct zero-extended bytes.
REQ-025 Full buffer: DEPTH issues accepted while the memory side is stalled.
  -> in_ready = 0; the next issue is held until one entry completes.
REQ-026 Flush with an outstanding request: entry 0 in MEM_WAIT, flush asserted, then a response for tag 0.
  -> no out_valid; entry 0 stays unallocatable until the response arrives, then becomes FREE.
REQ-027 out_stall held high for 3 cycles with a DONE entry.
  -> out_valid and out_data stable; entry freed on the cycle after out_stall drops.
